// File: rtl/boid_pkg.sv
// Shared definitions for the boid accelerator rule stage.
// Holds the default word width, the accumulator-width helper, the
// rule-accumulator state enum and the default squared ranges.
package boid_pkg;

    localparam int DW_DEF = 16;

    // Squared ranges are 2*DW+2 bits wide; these defaults assume DW_DEF.
    localparam logic [2*DW_DEF+1:0] VIS_SQ_DEF  = 34'd1600;
    localparam logic [2*DW_DEF+1:0] PROT_SQ_DEF = 34'd64;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } rule_state_t;

    // Accumulator width: enough headroom to add n DW-bit words without overflow.
    function automatic int aw_f(input int dw, input int n);
        return dw + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/boid_dist_sq.sv
// Combinational squared-distance unit.
// Ports: ax/ay (point a), bx/by (point b), all DW-bit signed;
//        dx/dy = a - b sign-extended to DW+1; d2 = dx^2 + dy^2 (2*DW+2 bits, unsigned).
module boid_dist_sq
    import boid_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0]        ax,
    input  logic [DW-1:0]        ay,
    input  logic [DW-1:0]        bx,
    input  logic [DW-1:0]        by,
    output logic signed [DW:0]   dx,
    output logic signed [DW:0]   dy,
    output logic [2*DW+1:0]      d2
);

    logic signed [2*DW+1:0] dx_ext_s;
    logic signed [2*DW+1:0] dy_ext_s;
    logic signed [2*DW+1:0] sq_x_s;
    logic signed [2*DW+1:0] sq_y_s;

    assign dx = {ax[DW-1], ax} - {bx[DW-1], bx};
    assign dy = {ay[DW-1], ay} - {by[DW-1], by};

    // |dx| < 2^DW, so each square is below 2^(2DW) and the sum fits in 2*DW+2 bits.
    assign dx_ext_s = {{(DW+1){dx[DW]}}, dx};
    assign dy_ext_s = {{(DW+1){dy[DW]}}, dy};
    assign sq_x_s   = dx_ext_s * dx_ext_s;
    assign sq_y_s   = dy_ext_s * dy_ext_s;
    assign d2       = $unsigned(sq_x_s + sq_y_s);

endmodule

// File: rtl/boid_rule_accum.sv
// Per-boid rule accumulator.
// Latches self on r_en_tot, classifies and accumulates one neighbour per
// r_en_itr (separation / alignment+cohesion), and on wb_en[0] snapshots the
// sums into registered outputs with a one-cycle out_valid pulse, then clears.
// Ports: clk, reset (sync, active-high); r_en_tot, r_en_itr, wb_en[6:0];
//        self_* and nb_* position/velocity words; sum_x/y/vx/vy, close_dx/dy,
//        nb_cnt, out_valid, busy (all registered).
module boid_rule_accum
    import boid_pkg::*;
#(
    parameter int                  num_boids = 2,
    parameter int                  DW        = DW_DEF,
    parameter logic [2*DW+1:0]     VIS_SQ    = VIS_SQ_DEF,
    parameter logic [2*DW+1:0]     PROT_SQ   = PROT_SQ_DEF,
    localparam int                 AW        = aw_f(DW, num_boids),
    localparam int                 CW        = $clog2(num_boids + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   r_en_tot,
    input  logic                   r_en_itr,
    input  logic [6:0]             wb_en,
    input  logic [DW-1:0]          self_x,
    input  logic [DW-1:0]          self_y,
    input  logic [DW-1:0]          self_vx,
    input  logic [DW-1:0]          self_vy,
    input  logic [DW-1:0]          nb_x,
    input  logic [DW-1:0]          nb_y,
    input  logic [DW-1:0]          nb_vx,
    input  logic [DW-1:0]          nb_vy,
    output logic signed [AW-1:0]   sum_x,
    output logic signed [AW-1:0]   sum_y,
    output logic signed [AW-1:0]   sum_vx,
    output logic signed [AW-1:0]   sum_vy,
    output logic signed [AW:0]     close_dx,
    output logic signed [AW:0]     close_dy,
    output logic [CW-1:0]          nb_cnt,
    output logic                   out_valid,
    output logic                   busy
);

    rule_state_t state_r, state_nxt_s;

    logic [DW-1:0]        self_x_r, self_y_r;
    logic signed [AW-1:0] acc_x_r, acc_y_r, acc_vx_r, acc_vy_r;
    logic signed [AW:0]   acc_cdx_r, acc_cdy_r;
    logic [CW-1:0]        acc_cnt_r;

    logic signed [AW-1:0] nxt_x_s, nxt_y_s, nxt_vx_s, nxt_vy_s;
    logic signed [AW:0]   nxt_cdx_s, nxt_cdy_s;
    logic [CW-1:0]        nxt_cnt_s;

    logic signed [DW:0]   dx_s, dy_s;
    logic [2*DW+1:0]      d2_s;
    logic                 take_s, fin_s;

    // Self velocity only matters to the later velocity-update stage.
    logic unused_s;
    assign unused_s = ^{wb_en[6:1], self_vx, self_vy};

    boid_dist_sq #(.DW(DW)) u_dist (
        .ax (self_x_r),
        .ay (self_y_r),
        .bx (nb_x),
        .by (nb_y),
        .dx (dx_s),
        .dy (dy_s),
        .d2 (d2_s)
    );

    // r_en_tot drops a same-cycle neighbour; finalize only happens from ACC.
    assign take_s = (state_r == ACC) && r_en_itr && !r_en_tot;
    assign fin_s  = (state_r == ACC) && wb_en[0];

    // Next-state logic: restart keeps ACC, finalize without restart returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (r_en_tot) state_nxt_s = ACC;
                else          state_nxt_s = IDLE;
            end
            ACC: begin
                if (r_en_tot)      state_nxt_s = ACC;
                else if (wb_en[0]) state_nxt_s = IDLE;
                else               state_nxt_s = ACC;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Accumulator next values: includes the current neighbour so a same-cycle finalize sees it.
    always_comb begin
        nxt_x_s   = acc_x_r;
        nxt_y_s   = acc_y_r;
        nxt_vx_s  = acc_vx_r;
        nxt_vy_s  = acc_vy_r;
        nxt_cdx_s = acc_cdx_r;
        nxt_cdy_s = acc_cdy_r;
        nxt_cnt_s = acc_cnt_r;
        if (!take_s || d2_s == {(2*DW+2){1'b0}}) begin
            nxt_cnt_s = acc_cnt_r;
        end else if (d2_s < PROT_SQ) begin
            nxt_cdx_s = acc_cdx_r + {{(AW-DW){dx_s[DW]}}, dx_s};
            nxt_cdy_s = acc_cdy_r + {{(AW-DW){dy_s[DW]}}, dy_s};
        end else if (d2_s < VIS_SQ) begin
            nxt_x_s   = acc_x_r  + {{(AW-DW){nb_x[DW-1]}},  nb_x};
            nxt_y_s   = acc_y_r  + {{(AW-DW){nb_y[DW-1]}},  nb_y};
            nxt_vx_s  = acc_vx_r + {{(AW-DW){nb_vx[DW-1]}}, nb_vx};
            nxt_vy_s  = acc_vy_r + {{(AW-DW){nb_vy[DW-1]}}, nb_vy};
            nxt_cnt_s = acc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            nxt_cnt_s = acc_cnt_r;
        end
    end

    // State, self latch, accumulators and snapshot outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            self_x_r  <= '0;
            self_y_r  <= '0;
            acc_x_r   <= '0;
            acc_y_r   <= '0;
            acc_vx_r  <= '0;
            acc_vy_r  <= '0;
            acc_cdx_r <= '0;
            acc_cdy_r <= '0;
            acc_cnt_r <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            sum_vx    <= '0;
            sum_vy    <= '0;
            close_dx  <= '0;
            close_dy  <= '0;
            nb_cnt    <= '0;
        end else begin
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s == ACC);
            out_valid <= fin_s;
            if (r_en_tot) begin
                self_x_r <= self_x;
                self_y_r <= self_y;
            end
            if (fin_s) begin
                sum_x    <= nxt_x_s;
                sum_y    <= nxt_y_s;
                sum_vx   <= nxt_vx_s;
                sum_vy   <= nxt_vy_s;
                close_dx <= nxt_cdx_s;
                close_dy <= nxt_cdy_s;
                nb_cnt   <= nxt_cnt_s;
            end
            if (r_en_tot || fin_s) begin
                acc_x_r   <= '0;
                acc_y_r   <= '0;
                acc_vx_r  <= '0;
                acc_vy_r  <= '0;
                acc_cdx_r <= '0;
                acc_cdy_r <= '0;
                acc_cnt_r <= '0;
            end else begin
                acc_x_r   <= nxt_x_s;
                acc_y_r   <= nxt_y_s;
                acc_vx_r  <= nxt_vx_s;
                acc_vy_r  <= nxt_vy_s;
                acc_cdx_r <= nxt_cdx_s;
                acc_cdy_r <= nxt_cdy_s;
                acc_cnt_r <= nxt_cnt_s;
            end
        end
    end

endmodule

// File: tb/tb_boid_rule_accum.sv
// Directed self-checking bench for boid_rule_accum (num_boids=2, DW=16).
module tb_boid_rule_accum;

    localparam int DW = 16;
    localparam int AW = 18;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset;
    logic r_en_tot, r_en_itr;
    logic [6:0] wb_en;
    logic [DW-1:0] self_x, self_y, self_vx, self_vy;
    logic [DW-1:0] nb_x, nb_y, nb_vx, nb_vy;
    logic signed [AW-1:0] sum_x, sum_y, sum_vx, sum_vy;
    logic signed [AW:0] close_dx, close_dy;
    logic [CW-1:0] nb_cnt;
    logic out_valid, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    boid_rule_accum dut (
        .clk(clk), .reset(reset), .r_en_tot(r_en_tot), .r_en_itr(r_en_itr), .wb_en(wb_en),
        .self_x(self_x), .self_y(self_y), .self_vx(self_vx), .self_vy(self_vy),
        .nb_x(nb_x), .nb_y(nb_y), .nb_vx(nb_vx), .nb_vy(nb_vy),
        .sum_x(sum_x), .sum_y(sum_y), .sum_vx(sum_vx), .sum_vy(sum_vy),
        .close_dx(close_dx), .close_dy(close_dy), .nb_cnt(nb_cnt),
        .out_valid(out_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge; controls return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        r_en_tot = 1'b0;
        r_en_itr = 1'b0;
        wb_en    = 7'd0;
    endtask

    task automatic latch_self(input int x, input int y);
        self_x = 16'(x);
        self_y = 16'(y);
        r_en_tot = 1'b1;
    endtask

    task automatic nb(input int x, input int y, input int vx, input int vy);
        nb_x = 16'(x);
        nb_y = 16'(y);
        nb_vx = 16'(vx);
        nb_vy = 16'(vy);
        r_en_itr = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        r_en_tot = 1'b0; r_en_itr = 1'b0; wb_en = 7'd0;
        self_x = 16'd0; self_y = 16'd0; self_vx = 16'd7; self_vy = 16'd9;
        nb_x = 16'd0; nb_y = 16'd0; nb_vx = 16'd0; nb_vy = 16'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_sum_x", sum_x, 18'sd0);
        chk("rst_close_dx", close_dx, 19'sd0);
        chk("rst_cnt", nb_cnt, 2'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Visual-range neighbour, finalize with upper wb_en bits set.
        latch_self(100, 100); tick();
        chk("busy_acc", busy, 1'b1);
        nb(120, 100, 3, -2); tick();
        wb_en = 7'b0011111; tick();
        chk("vis_valid", out_valid, 1'b1);
        chk("vis_sum_x", sum_x, 18'sd120);
        chk("vis_sum_y", sum_y, 18'sd100);
        chk("vis_sum_vx", sum_vx, 18'sd3);
        chk("vis_sum_vy", sum_vy, -18'sd2);
        chk("vis_cnt", nb_cnt, 2'd1);
        chk("vis_cdx", close_dx, 19'sd0);
        chk("vis_busy", busy, 1'b0);
        tick();
        chk("pulse_once", out_valid, 1'b0);
        chk("hold_sum_x", sum_x, 18'sd120);

        // Protected neighbour plus out-of-range neighbour.
        latch_self(100, 100); tick();
        nb(104, 103, 5, 5); tick();
        nb(200, 100, 5, 5); tick();
        wb_en = 7'd1; tick();
        chk("sep_cdx", close_dx, -19'sd4);
        chk("sep_cdy", close_dy, -19'sd3);
        chk("sep_cnt", nb_cnt, 2'd0);
        chk("sep_sum_x", sum_x, 18'sd0);

        // Coincident skipped; d2 == PROT_SQ goes to the visual rule.
        latch_self(100, 100); tick();
        nb(100, 100, 1, 1); tick();
        nb(108, 100, 0, 0); tick();
        wb_en = 7'd1; tick();
        chk("edge_cnt", nb_cnt, 2'd1);
        chk("edge_sum_x", sum_x, 18'sd108);
        chk("edge_cdx", close_dx, 19'sd0);

        // r_en_tot with r_en_itr in ACC drops the neighbour.
        latch_self(100, 100); tick();
        latch_self(100, 100); nb(120, 100, 3, 3); tick();
        wb_en = 7'd1; tick();
        chk("drop_cnt", nb_cnt, 2'd0);
        chk("drop_sum_x", sum_x, 18'sd0);

        // Restart after one accumulated neighbour clears the sums.
        latch_self(100, 100); tick();
        nb(120, 100, 3, 3); tick();
        latch_self(100, 100); tick();
        wb_en = 7'd1; tick();
        chk("restart_valid", out_valid, 1'b1);
        chk("restart_cnt", nb_cnt, 2'd0);
        chk("restart_sum_vx", sum_vx, 18'sd0);

        // Finalize in IDLE is ignored.
        tick();
        wb_en = 7'd1; tick();
        chk("idle_wb_valid", out_valid, 1'b0);
        chk("idle_wb_busy", busy, 1'b0);

        // Neighbour arriving with finalize is included.
        latch_self(100, 100); tick();
        nb(120, 100, 3, -2); wb_en = 7'd1; tick();
        chk("same_valid", out_valid, 1'b1);
        chk("same_cnt", nb_cnt, 2'd1);
        chk("same_sum_x", sum_x, 18'sd120);

        // Finalize with restart: old sums out, stays in ACC with new self (0,0).
        latch_self(100, 100); tick();
        nb(120, 100, 3, -2); tick();
        latch_self(0, 0); wb_en = 7'd1; tick();
        chk("finrst_valid", out_valid, 1'b1);
        chk("finrst_sum_x", sum_x, 18'sd120);
        chk("finrst_busy", busy, 1'b1);
        nb(10, 0, 1, 1); tick();
        wb_en = 7'd1; tick();
        chk("new_sum_x", sum_x, 18'sd10);
        chk("new_sum_vx", sum_vx, 18'sd1);
        chk("new_cnt", nb_cnt, 2'd1);

        // Reset mid-ACC discards everything.
        latch_self(100, 100); tick();
        nb(120, 100, 3, -2); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        wb_en = 7'd1; tick();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_sum_x", sum_x, 18'sd0);
        chk("rst_mid_cnt", nb_cnt, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
